uart_rx_osr: RTL and testbench
==============================

// Module: uart_rx_osr
// PURPOSE
//   UART 8N1 receiver and consumer of the fractional-N baud generator's tick_osr strobe.
//   Oversamples the asynchronous rx line at OSR ticks per bit and locates the start-bit centre.
//   Samples each bit at its mid-point and delivers bytes via a valid/ready holding register.
//   Reports framing and overrun errors. Sits beside the UART TX in the top-level serial path.
// PARAMETERS
//   OSR          16   tick_osr strobes per bit; even, >= 4
//   DATA_BITS    8    data bits per frame, LSB first
//   SYNC_STAGES  2    flip-flop stages in the rx input synchronizer, >= 2
// PORTS
//   clk        in   1          system clock; one clock domain
//   rst        in   1          asynchronous, active-high reset
//   tick_osr   in   1          1-clk strobe at BAUD*OSR, from the baud generator
//   rx         in   1          serial input, asynchronous, idle high
//   rx_data    out  DATA_BITS  received byte; valid while rx_valid=1
//   rx_valid   out  1          byte available; held until accepted
//   rx_ready   in   1          consumer accepts the byte when rx_valid & rx_ready
//   frame_err  out  1          1-clk pulse: stop bit sampled as 0
//   overrun    out  1          1-clk pulse: new byte dropped, holding register full
//   busy       out  1          1 in any state other than IDLE
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-high.
//   Reset values:
//     - synchronizer chain = 1, state = IDLE, all counters = 0
//     - rx_data = 0; rx_valid, frame_err, overrun, busy = 0
//   Reset mid-frame aborts the frame immediately. No partial byte is ever delivered.
//   Pacing: os_cnt ($clog2(OSR) bits) and bit_cnt advance only on cycles with tick_osr=1.
//     State and counters hold between ticks. The synchronized line rx_s is used everywhere.
//   FSM states:
//     IDLE:    on tick & rx_s=0 -> START, os_cnt=0
//     START:   on tick, os_cnt++
//              at os_cnt==OSR/2-1: rx_s=0 -> DATA, os_cnt=0, bit_cnt=0
//                                  rx_s=1 (glitch) -> IDLE, no outputs
//     DATA:    on tick, os_cnt++
//              at os_cnt==OSR-1: shift rx_s into MSB of shreg (LSB-first reception),
//                os_cnt=0, bit_cnt++
//              after the DATA_BITS-th sample -> STOP
//     STOP:    at os_cnt==OSR-1, sample rx_s
//              rx_s=1 -> deliver, then IDLE
//              rx_s=0 -> frame_err pulse, byte discarded, then WAIT_HI
//     WAIT_HI: stay until rx_s=1 on a tick, then IDLE (prevents break/line-low retrigger)
//   Deliver: on the clk after the stop-sample tick:
//     - holding empty, or (rx_valid & rx_ready) in that same cycle ->
//       rx_data = shreg, rx_valid = 1
//     - holding full and not accepted -> overrun pulse; old rx_data kept; new byte lost
//   rx_valid clears on the cycle after (rx_valid & rx_ready) unless a delivery coincides.
//     A coinciding delivery keeps rx_valid=1 and loads the new rx_data.
//   frame_err and overrun never assert in the same cycle. Neither is ever wider than 1 clk.
//   Latency: stop sample to rx_valid = 1 clk. Start edge to rx_valid ~ (1.5+DATA_BITS)*OSR ticks.
//   tick_osr spacing jitters between N0 and N0+1 clocks. The design tolerates this with no
//     dependence on exact spacing.
// STRUCTURE
//   uart_pkg:
//     - rx_state_t: IDLE, START, DATA, STOP, WAIT_HI
//     - default OSR and DATA_BITS constants, shared with uart_tx
//   Sub-module sync_ff (SYNC_STAGES-deep, reset value 1) for the rx input.
//   FSM, counters, shift register and holding register stay in uart_rx_osr.
// TESTING (F_CLK=50 MHz, BAUD=115200, OSR=16, driven by the fractional baud generator)
//   1. Send 0xA5 8N1, rx_ready=1
//      -> one rx_valid pulse with rx_data=8'hA5; frame_err=0, overrun=0
//   2. rx low for 3 tick_osr, then high
//      -> back to IDLE, busy drops, no rx_valid, no frame_err
//   3. Send 0x3C with stop bit=0, rx held low 2 more bit times
//      -> frame_err 1-clk pulse, no rx_valid, stays WAIT_HI until rx=1
//   4. Send 0x00 then 0xFF back-to-back, rx_ready=0
//      -> rx_valid=1, rx_data=8'h00, overrun pulse at the end of the second frame
//   5. Assert rst mid-DATA of 0x81
//      -> outputs 0 immediately; the following 0x5A frame is received correctly
//   6. Ten 0x55 frames, rx_ready=1
//      -> exactly 10 rx_valid acceptances in order, no errors

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receiver state encoding.
package uart_pkg;
    localparam int OSR_DEF       = 16;
    localparam int DATA_BITS_DEF = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage synchronizer for an asynchronous input, resets to 1 (line idle).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_chain;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_chain <= '1;
        else     r_chain <= {r_chain[STAGES-2:0], i_d};
    assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/uart_rx_osr.sv
// uart_rx_osr: oversampling 8N1 UART receiver with valid/ready holding register,
// framing-error and overrun pulses. Paced entirely by the tick_osr strobe.
module uart_rx_osr
    import uart_pkg::*;
#(
    parameter int OSR         = OSR_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_osr,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int OW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS + 1);
    rx_state_t            r_state, w_state_nx;
    logic [OW-1:0]        r_os_cnt, w_os_nx;
    logic [BW-1:0]        r_bit_cnt, w_bit_nx;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_nx;
    logic                 w_rx_s, w_stop_ok, w_stop_bad, w_load;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .i_d(rx), .o_q(w_rx_s));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_os_cnt  <= w_os_nx;
            r_bit_cnt <= w_bit_nx;
            r_shreg   <= w_shreg_nx;
        end

    always_comb begin
        w_state_nx = r_state;
        w_os_nx    = r_os_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shreg_nx = r_shreg;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        if (tick_osr)
            case (r_state)
                IDLE:
                    if (!w_rx_s) begin
                        w_state_nx = START;
                        w_os_nx    = '0;
                    end
                START:
                    if (r_os_cnt == OW'(OSR/2 - 1)) begin
                        w_os_nx    = '0;
                        w_bit_nx   = '0;
                        w_state_nx = w_rx_s ? IDLE : DATA;
                    end else w_os_nx = r_os_cnt + 1'b1;
                DATA:
                    if (r_os_cnt == OW'(OSR - 1)) begin
                        w_os_nx    = '0;
                        w_shreg_nx = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        w_bit_nx   = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BW'(DATA_BITS - 1)) w_state_nx = STOP;
                    end else w_os_nx = r_os_cnt + 1'b1;
                STOP:
                    if (r_os_cnt == OW'(OSR - 1)) begin
                        w_os_nx    = '0;
                        w_stop_ok  = w_rx_s;
                        w_stop_bad = !w_rx_s;
                        // a low stop bit may be a break; wait for the line to return high
                        w_state_nx = w_rx_s ? IDLE : WAIT_HI;
                    end else w_os_nx = r_os_cnt + 1'b1;
                WAIT_HI:
                    if (w_rx_s) w_state_nx = IDLE;
                default:
                    w_state_nx = IDLE;
            endcase
    end

    assign w_load = w_stop_ok && (!rx_valid || rx_ready);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_bad;
            overrun   <= w_stop_ok && rx_valid && !rx_ready;
            if (w_load) begin
                rx_data  <= r_shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) rx_valid <= 1'b0;
        end

    assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_osr.sv
// tb_uart_rx_osr: scoreboard bench for uart_rx_osr with a jittering fractional tick source.
module tb_uart_rx_osr;
    localparam int OSR = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_osr = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    int         checks = 0, errors = 0;
    int         n_acc = 0, n_ferr = 0, n_ovr = 0;
    int         acc = 0;
    logic       p_ferr = 1'b0, p_ovr = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_osr #(.OSR(OSR), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick_osr(tick_osr), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #10 clk = ~clk;

    // 2/9 ticks per clock: spacing alternates between 4 and 5 clocks
    always @(negedge clk) begin
        if (acc + 2 >= 9) begin
            acc = acc + 2 - 9;
            tick_osr = 1'b1;
        end else begin
            acc = acc + 2;
            tick_osr = 1'b0;
        end
    end

    always @(negedge clk) if (!rst) begin
        if (rx_valid && rx_ready) begin
            n_acc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %h, none expected", rx_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data: got %h, expected %h", rx_data, e);
                end
            end
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
        if (frame_err === 1'b1 || overrun === 1'b1) begin
            checks++;
            if ((frame_err && overrun) || (frame_err && p_ferr) || (overrun && p_ovr)) begin
                errors++;
                $display("FAIL err_pulse: frame_err=%b overrun=%b prev=%b/%b, expected single 1-clk pulse",
                         frame_err, overrun, p_ferr, p_ovr);
            end
        end
        p_ferr = frame_err;
        p_ovr  = overrun;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick_osr !== 1'b1);
        end
    endtask

    task automatic set_rx(input logic v);
        @(negedge clk);
        rx = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        set_rx(1'b0);
        wait_ticks(OSR);
        for (int i = 0; i < 8; i++) begin
            set_rx(b[i]);
            wait_ticks(OSR);
        end
        set_rx(stop);
        wait_ticks(OSR);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        wait_ticks(OSR);
    endtask

    task automatic test_single_byte;
        int a0 = n_acc, f0 = n_ferr, o0 = n_ovr;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_ticks(OSR);
        @(negedge clk);
        chk("a5_accepts", n_acc - a0, 1);
        chk("a5_ferr", n_ferr - f0, 0);
        chk("a5_ovr", n_ovr - o0, 0);
        chk("a5_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_glitch;
        int a0 = n_acc, f0 = n_ferr;
        set_rx(1'b0);
        wait_ticks(3);
        @(negedge clk);
        chk("glitch_busy_high", busy, 1);
        rx = 1'b1;
        wait_ticks(OSR);
        @(negedge clk);
        chk("glitch_busy_low", busy, 0);
        chk("glitch_accepts", n_acc - a0, 0);
        chk("glitch_ferr", n_ferr - f0, 0);
    endtask

    task automatic test_frame_err;
        int a0 = n_acc, f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        wait_ticks(2 * OSR);
        @(negedge clk);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_accepts", n_acc - a0, 0);
        chk("ferr_wait_hi_busy", busy, 1);
        rx = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        chk("ferr_idle_after_high", busy, 0);
    endtask

    task automatic test_overrun;
        int o0 = n_ovr, f0 = n_ferr;
        @(negedge clk);
        rx_ready = 1'b0;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(OSR);
        @(negedge clk);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_ferr", n_ferr - f0, 0);
        chk("ovr_valid_held", rx_valid, 1);
        chk("ovr_data_kept", rx_data, 8'h00);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_valid_cleared", rx_valid, 0);
        chk("ovr_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_back_to_back;
        int a0 = n_acc, f0 = n_ferr, o0 = n_ovr;
        rx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(8'h55);
            send_frame(8'h55, 1'b1);
        end
        wait_ticks(OSR);
        @(negedge clk);
        chk("b2b_accepts", n_acc - a0, 10);
        chk("b2b_ferr", n_ferr - f0, 0);
        chk("b2b_ovr", n_ovr - o0, 0);
        chk("b2b_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b = 8'h81;
        int a0, f0, o0;
        set_rx(1'b0);
        wait_ticks(OSR);
        for (int i = 0; i < 4; i++) begin
            set_rx(b[i]);
            wait_ticks(OSR);
        end
        @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        chk("rst_mid_data_before", rx_data, 8'h55);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_data", rx_data, 0);
        chk("rst_mid_rx_valid", rx_valid, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(OSR);
        a0 = n_acc;
        f0 = n_ferr;
        o0 = n_ovr;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_ticks(OSR);
        @(negedge clk);
        chk("rst_after_accepts", n_acc - a0, 1);
        chk("rst_after_errs", (n_ferr - f0) + (n_ovr - o0), 0);
        chk("rst_after_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
